// File: rtl/handshake_tx_if.sv
// Bundle of signals between the local sender, the handshake_tx block and the remote
// four-phase receiver. The master modport is the block's view; the slave modport is its environment.
interface handshake_tx_if #(
  parameter int DATA_W = 8
);
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_ready;
  logic              req_out;
  logic [DATA_W-1:0] data_out;
  logic              ack_in;
  logic              done;
  logic              err;

  modport master (
    input  tx_valid, tx_data, ack_in,
    output tx_ready, req_out, data_out, done, err
  );

  modport slave (
    output tx_valid, tx_data, ack_in,
    input  tx_ready, req_out, data_out, done, err
  );
endinterface

// File: rtl/handshake_tx.sv
// Four-phase request/acknowledge transmitter toward an asynchronous domain.
// It sends one word per handshake and has an ack timeout while waiting for the acknowledge.
module handshake_tx #(
  parameter int DATA_W    = 8,
  parameter int TO_CYCLES = 64
) (
  input  logic            clk,
  input  logic            rst,
  handshake_tx_if.master  bus
);

  typedef enum logic [1:0] {IDLE, REQ, RELEASE} state_e;

  localparam logic [7:0] TO_LAST = 8'(TO_CYCLES - 1);

  state_e            state_q, state_d;
  logic              ack_meta_q, ack_s_q;
  logic [7:0]        cnt_q, cnt_d;
  logic              req_q, req_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              rdy_q;
  logic              done_c, err_c;

  // ack_in is asynchronous to clk; only ack_s_q is used past this point
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_meta_q <= 1'b0;
      ack_s_q    <= 1'b0;
    end else begin
      ack_meta_q <= bus.ack_in;
      ack_s_q    <= ack_meta_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      data_q  <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      data_q  <= data_d;
      rdy_q   <= (state_d == IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    data_d  = data_q;
    done_c  = 1'b0;
    err_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.tx_valid && rdy_q) begin
          data_d  = bus.tx_data;
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        // ack is checked first, so an ack on the timeout cycle counts as done
        if (ack_s_q) begin
          done_c  = 1'b1;
          req_d   = 1'b0;
          state_d = RELEASE;
        end else if (cnt_q == TO_LAST) begin
          err_c   = 1'b1;
          req_d   = 1'b0;
          state_d = RELEASE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RELEASE: begin
        if (!ack_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.tx_ready = rdy_q;
  assign bus.req_out  = req_q;
  assign bus.data_out = data_q;
  assign bus.done     = done_c;
  assign bus.err      = err_c;

endmodule

// File: tb/tb_handshake_tx.sv
// Directed bench for handshake_tx (DATA_W=8, TO_CYCLES=8). The bench drives inputs on negedges
// and samples outputs there. A posedge monitor counts the done and err pulses.
module tb_handshake_tx;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  handshake_tx_if #(.DATA_W(8)) bus ();

  handshake_tx #(.DATA_W(8), .TO_CYCLES(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int both_cnt = 0;

  always @(posedge clk) begin
    if (!rst) begin
      if (bus.done) done_cnt++;
      if (bus.err) err_cnt++;
      if (bus.done && bus.err) both_cnt++;
    end
  end

  task automatic test_reset();
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    bus.ack_in   = 1'b0;
    #1 rst = 1'b1;
    #21;
    tests++; if (bus.tx_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b want 0", bus.tx_ready); end
    tests++; if (bus.req_out !== 1'b0) begin fails++; $display("FAIL reset_req: got %b want 0", bus.req_out); end
    tests++; if (bus.data_out !== 8'h00) begin fails++; $display("FAIL reset_data: got %h want 00", bus.data_out); end
    tests++; if ({bus.done, bus.err} !== 2'b00) begin fails++; $display("FAIL reset_pulses: got %b want 00", {bus.done, bus.err}); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++; if (bus.tx_ready !== 1'b0) begin fails++; $display("FAIL ready_before_edge: got %b want 0", bus.tx_ready); end
    @(negedge clk);
    tests++; if (bus.tx_ready !== 1'b1) begin fails++; $display("FAIL ready_first_edge: got %b want 1", bus.tx_ready); end
  endtask

  task automatic test_basic();
    int n = 0;
    int d0 = done_cnt;
    int e0 = err_cnt;
    int unstable = 0;
    int w = 0;
    bus.tx_data  = 8'hA5;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    tests++; if (bus.tx_ready !== 1'b0) begin fails++; $display("FAIL basic_ready_low: got %b want 0", bus.tx_ready); end
    while (bus.req_out === 1'b1 && n < 20) begin
      n++;
      if (bus.data_out !== 8'hA5) unstable++;
      if (n == 3) bus.ack_in = 1'b1;
      @(negedge clk);
    end
    tests++; if (n !== 5) begin fails++; $display("FAIL basic_req_len: got %0d want 5", n); end
    repeat (2) begin
      if (bus.data_out !== 8'hA5) unstable++;
      @(negedge clk);
    end
    bus.ack_in = 1'b0;
    while (bus.tx_ready !== 1'b1 && w < 20) begin
      if (bus.data_out !== 8'hA5) unstable++;
      w++;
      @(negedge clk);
    end
    tests++; if (w >= 20) begin fails++; $display("FAIL basic_ready_return: waited %0d cycles, limit 20", w); end
    tests++; if (unstable !== 0 || bus.data_out !== 8'hA5) begin fails++; $display("FAIL basic_data: got %h (%0d unstable) want A5", bus.data_out, unstable); end
    tests++; if (done_cnt - d0 !== 1) begin fails++; $display("FAIL basic_done: got %0d want 1", done_cnt - d0); end
    tests++; if (err_cnt - e0 !== 0) begin fails++; $display("FAIL basic_err: got %0d want 0", err_cnt - e0); end
  endtask

  task automatic test_timeout();
    int n = 0;
    int err_at = 0;
    int d0 = done_cnt;
    bus.ack_in   = 1'b0;
    bus.tx_data  = 8'h5A;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    while (bus.req_out === 1'b1 && n < 20) begin
      n++;
      if (bus.err === 1'b1) err_at = n;
      @(negedge clk);
    end
    tests++; if (n !== 8) begin fails++; $display("FAIL to_req_len: got %0d want 8", n); end
    tests++; if (err_at !== 8) begin fails++; $display("FAIL to_err_cycle: got %0d want 8", err_at); end
    tests++; if (done_cnt - d0 !== 0) begin fails++; $display("FAIL to_done: got %0d want 0", done_cnt - d0); end
    tests++; if (bus.tx_ready !== 1'b0) begin fails++; $display("FAIL to_release_ready: got %b want 0", bus.tx_ready); end
    @(negedge clk);
    tests++; if (bus.tx_ready !== 1'b1) begin fails++; $display("FAIL to_idle_next: got %b want 1", bus.tx_ready); end
  endtask

  task automatic test_tie();
    int n = 0;
    int done_at = 0;
    int e0 = err_cnt;
    int busy = 0;
    int w = 0;
    bus.tx_data  = 8'hC3;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    while (bus.req_out === 1'b1 && n < 20) begin
      n++;
      if (bus.done === 1'b1) done_at = n;
      if (n == 6) bus.ack_in = 1'b1;
      @(negedge clk);
    end
    tests++; if (n !== 8) begin fails++; $display("FAIL tie_req_len: got %0d want 8", n); end
    tests++; if (done_at !== 8) begin fails++; $display("FAIL tie_done_cycle: got %0d want 8", done_at); end
    tests++; if (err_cnt - e0 !== 0) begin fails++; $display("FAIL tie_err: got %0d want 0", err_cnt - e0); end
    repeat (4) begin
      if (bus.tx_ready === 1'b0) busy++;
      @(negedge clk);
    end
    tests++; if (busy !== 4) begin fails++; $display("FAIL tie_wait_release: got %0d busy cycles want 4", busy); end
    bus.ack_in = 1'b0;
    while (bus.tx_ready !== 1'b1 && w < 20) begin w++; @(negedge clk); end
    tests++; if (w >= 20) begin fails++; $display("FAIL tie_ready_return: waited %0d cycles, limit 20", w); end
  endtask

  task automatic test_rst_mid();
    int d0 = done_cnt;
    int e0 = err_cnt;
    bus.tx_data  = 8'h3C;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (bus.req_out !== 1'b1) begin fails++; $display("FAIL rst_pre_req: got %b want 1", bus.req_out); end
    #2 rst = 1'b1;
    #1;
    tests++; if (bus.req_out !== 1'b0) begin fails++; $display("FAIL rst_async_req: got %b want 0", bus.req_out); end
    tests++; if (bus.data_out !== 8'h00) begin fails++; $display("FAIL rst_async_data: got %h want 00", bus.data_out); end
    tests++; if ({bus.done, bus.err, bus.tx_ready} !== 3'b000) begin fails++; $display("FAIL rst_async_flags: got %b want 000", {bus.done, bus.err, bus.tx_ready}); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++; if (bus.tx_ready !== 1'b1) begin fails++; $display("FAIL rst_ready_after: got %b want 1", bus.tx_ready); end
    repeat (3) @(negedge clk);
    tests++; if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0 || bus.req_out !== 1'b0) begin
      fails++; $display("FAIL rst_no_pulse: done %0d err %0d req %b want 0 0 0", done_cnt - d0, err_cnt - e0, bus.req_out);
    end
  endtask

  task automatic test_back_to_back();
    int d0 = done_cnt;
    int e0 = err_cnt;
    int cyc = 0;
    int acc = 0;
    int acc_cyc[2];
    logic [7:0] acc_data[2];
    logic prev_ready = bus.tx_ready;
    logic prev_valid;
    logic req_prev = 1'b0;
    logic [7:0] last_data = bus.data_out;
    int bad = 0;
    bus.tx_data  = 8'h01;
    bus.tx_valid = 1'b1;
    while (cyc < 80 && !(done_cnt - d0 >= 2 && bus.tx_ready === 1'b1)) begin
      prev_valid = bus.tx_valid;
      @(negedge clk);
      cyc++;
      bus.ack_in = req_prev;
      req_prev   = bus.req_out;
      if (prev_ready && prev_valid) begin
        if (acc < 2) begin acc_cyc[acc] = cyc; acc_data[acc] = bus.data_out; end
        acc++;
        if (acc == 1) bus.tx_data = 8'h02;
        else bus.tx_valid = 1'b0;
      end else if (bus.data_out !== last_data) begin
        bad++;
      end
      last_data  = bus.data_out;
      prev_ready = bus.tx_ready;
    end
    bus.tx_valid = 1'b0;
    bus.ack_in   = 1'b0;
    tests++; if (acc !== 2) begin fails++; $display("FAIL b2b_accepts: got %0d want 2", acc); end
    if (acc >= 2) begin
      tests++; if (acc_data[0] !== 8'h01 || acc_data[1] !== 8'h02) begin fails++; $display("FAIL b2b_data_seq: got %h %h want 01 02", acc_data[0], acc_data[1]); end
      tests++; if (acc_cyc[1] - acc_cyc[0] < 6) begin fails++; $display("FAIL b2b_gap: got %0d want >=6", acc_cyc[1] - acc_cyc[0]); end
    end
    tests++; if (bad !== 0) begin fails++; $display("FAIL b2b_early_capture: got %0d data changes outside acceptance want 0", bad); end
    tests++; if (done_cnt - d0 !== 2 || err_cnt - e0 !== 0) begin fails++; $display("FAIL b2b_pulses: done %0d err %0d want 2 0", done_cnt - d0, err_cnt - e0); end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_stray();
    int d0 = done_cnt;
    int e0 = err_cnt;
    int bad = 0;
    for (int i = 0; i < 12; i++) begin
      bus.ack_in = (i < 5);
      @(negedge clk);
      if (bus.req_out !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0 || bus.tx_ready !== 1'b1) bad++;
    end
    tests++; if (bad !== 0) begin fails++; $display("FAIL stray_outputs: got %0d disturbed cycles want 0", bad); end
    tests++; if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0) begin fails++; $display("FAIL stray_pulses: done %0d err %0d want 0 0", done_cnt - d0, err_cnt - e0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_tie();
    test_rst_mid();
    test_back_to_back();
    test_stray();
    tests++; if (both_cnt !== 0) begin fails++; $display("FAIL done_err_overlap: got %0d want 0", both_cnt); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/handshake_tx.md
HANDSHAKE_TX -- requirements
Module: handshake_tx

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the width of the transferred word.
REQ-002 Parameter TO_CYCLES, default 64, range 4..255, SHALL set the ack timeout length in clock cycles.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  SHALL be the single clock; all state updates occur on the rising edge.
REQ-005 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-006 tx_valid  input  1  SHALL indicate that the local side presents a word to send.
REQ-007 tx_data  input  DATA_W  SHALL carry the word, sampled only on acceptance.
REQ-008 tx_ready  output  1  SHALL indicate that the block can accept a word.
REQ-009 req_out  output  1  SHALL be the four-phase request to the remote, asynchronous domain.
REQ-010 data_out  output  DATA_W  SHALL be the word driven to the remote domain.
REQ-011 ack_in  input  1  SHALL be the remote acknowledge, asynchronous to clk.
REQ-012 done  output  1  SHALL be a one-cycle pulse marking an acknowledged transfer.
REQ-013 err  output  1  SHALL be a one-cycle pulse marking an ack timeout.

Function
REQ-014 ack_in SHALL pass through a two-flop synchronizer (ack_s) before any use; no logic SHALL read raw ack_in.
REQ-015 The FSM SHALL have exactly three states: IDLE, REQ, RELEASE.
REQ-016 tx_ready SHALL be 1 only in IDLE, and SHALL be driven from registered state.
REQ-017 Acceptance SHALL occur when tx_valid=1 and tx_ready=1 at a rising edge.
- On that edge: data_out<=tx_data, req_out<=1, timeout counter<=0, state<=REQ.
REQ-018 req_out and data_out SHALL be registered outputs, with no combinational path from any input.
REQ-019 data_out SHALL hold its value from acceptance until the next acceptance.
REQ-020 In REQ, when ack_s=1: req_out<=0, done=1 for one cycle, state<=RELEASE.
REQ-021 In REQ, when ack_s=0: the counter SHALL increment.
- When the counter equals TO_CYCLES-1 with ack_s=0: req_out<=0, err=1 for one cycle, state<=RELEASE.
REQ-022 If ack_s=1 on the same edge as the timeout condition, the ack SHALL win: done=1, err=0.
REQ-023 In RELEASE, when ack_s=0: state<=IDLE, so tx_ready=1 on the following cycle.
- RELEASE SHALL have no timeout.
REQ-024 In RELEASE, if ack_s=0 on the first cycle (after a timeout with ack never seen), the block SHALL return to IDLE immediately.
REQ-025 tx_valid SHALL be ignored outside IDLE, and no word SHALL be queued.
REQ-026 done and err SHALL never be 1 in the same cycle.
REQ-027 The minimum transfer time SHALL be 1 cycle (accept) + 2 cycles (ack sync rise) + 2 cycles (ack sync fall) + 1 cycle (IDLE), giving back-to-back acceptances at least 6 cycles apart.
REQ-028 An ack_in pulse arriving in IDLE SHALL be synchronized but SHALL cause no state change or output.

Reset
REQ-029 While rst=1, independent of clk: state=IDLE, req_out=0, data_out=0, done=0, err=0, counter=0, both synchronizer flops=0, tx_ready=0.
REQ-030 tx_ready SHALL become 1 on the first rising edge after rst deasserts.
REQ-031 Reset asserted mid-transfer SHALL drop req_out to 0 immediately, with no done or err pulse.
- A word in flight at reset SHALL be abandoned.

Verification
REQ-032 Basic transfer: DATA_W=8; tx_data=0xA5 accepted; remote raises ack_in 3 cycles after req_out rises and drops it 3 cycles after req_out falls.
- Required: data_out=0xA5 stable throughout, one done pulse, zero err pulses.
- Required: tx_ready returns to 1, and req_out is high for exactly 3+2 cycles before falling.
REQ-033 Timeout: TO_CYCLES=8; ack_in held 0.
- Required: req_out high exactly 8 cycles, err pulse at the 8th REQ cycle, done=0.
- Required: IDLE one cycle after entering RELEASE.
REQ-034 Tie: TO_CYCLES=8; ack_in timed so that ack_s rises on the 8th REQ cycle.
- Required: done=1, err=0, and the FSM then waits in RELEASE for ack_s=0.
REQ-035 Reset mid-REQ: rst pulsed high while req_out=1.
- Required: req_out=0 and data_out=0 asynchronously, no done or err pulse.
- Required: tx_ready=1 on the first edge after release.
REQ-036 Back-to-back: tx_valid held 1 with 0x01 then 0x02, remote responding with 1-cycle ack latency.
- Required: two done pulses, data_out sequence 0x01 then 0x02.
- Required: acceptances at least 6 cycles apart, and 0x02 not captured before tx_ready=1.
REQ-037 Stray ack: ack_in pulsed for 5 cycles while IDLE.
- Required: no change on req_out, done or err, and tx_ready stays 1.
